// File: rtl/useq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : useq_pkg
// Description : Shared types and default widths for the micro-sequencer
//               branch controller and its return stack.
// Revision    : 1.0 - initial release
// ============================================================================
package useq_pkg;

    localparam int UPC_W_DEF       = 5;
    localparam int STACK_DEPTH_DEF = 4;
    localparam int CNT_W_DEF       = 5;
    localparam int WAIT_MAX_DEF    = 15;

    // Sequencing field of the microinstruction
    typedef enum logic [2:0] {
        BR_NEXT  = 3'd0,
        BR_JMP   = 3'd1,
        BR_JC    = 3'd2,
        BR_JNC   = 3'd3,
        BR_CALL  = 3'd4,
        BR_RET   = 3'd5,
        BR_LDCNT = 3'd6,
        BR_DJNZ  = 3'd7
    } br_type_e;

    // Controller state; FAULT is only left through reset
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } useq_state_e;

endpackage : useq_pkg
`default_nettype wire

// File: rtl/useq_stack.sv
`default_nettype none
// ============================================================================
// Module      : useq_stack
// Description : Return-address LIFO. Top of stack is visible combinationally
//               on dout; push and pop take effect on the rising edge. The
//               caller guarantees no push when full and no pop when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module useq_stack
    import useq_pkg::*;
#(
    parameter int UPC_W       = UPC_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [UPC_W-1:0]               din,
    output logic [UPC_W-1:0]               dout,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           full,
    output logic                           empty
);

    localparam int AW = $clog2(STACK_DEPTH);
    localparam int DW = AW + 1;
    localparam logic [DW-1:0] c_FULL = DW'(STACK_DEPTH);

    logic [UPC_W-1:0] r_mem [STACK_DEPTH];
    logic [DW-1:0]    r_depth;
    logic [DW-1:0]    w_depth_m1;

    // Top entry sits one below the occupancy count
    always_comb begin
        w_depth_m1 = r_depth - 1'b1;
        dout       = r_mem[w_depth_m1[AW-1:0]];
        depth      = r_depth;
        full       = (r_depth == c_FULL);
        empty      = (r_depth == '0);
    end

    // Occupancy counter; cleared asynchronously so a reset empties the stack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_depth <= '0;
        end else if (push) begin
            r_depth <= r_depth + 1'b1;
        end else if (pop) begin
            r_depth <= r_depth - 1'b1;
        end
    end

    // Storage needs no reset: entries above depth are never read
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_depth[AW-1:0]] <= din;
        end
    end

endmodule : useq_stack
`default_nettype wire

// File: rtl/useq_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : useq_branch_ctrl
// Description : Micro-sequencer branch controller. Decodes the sequencing
//               field each cycle and drives load_incr/upc_next into the upc
//               register with zero latency. Holds on memory wait, parks at
//               FAULT_VEC on stack misuse or wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module useq_branch_ctrl
    import useq_pkg::*;
#(
    parameter int               UPC_W       = UPC_W_DEF,
    parameter int               STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int               CNT_W       = CNT_W_DEF,
    parameter int               WAIT_MAX    = WAIT_MAX_DEF,
    parameter logic [UPC_W-1:0] FAULT_VEC   = 5'h1F
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [UPC_W-1:0]               upc,
    input  logic [2:0]                     br_type,
    input  logic [UPC_W-1:0]               br_addr,
    input  logic [1:0]                     cond_sel,
    input  logic [3:0]                     flags,
    input  logic                           uwait,
    input  logic                           mem_ready,
    output logic                           load_incr,
    output logic [UPC_W-1:0]               upc_next,
    output logic                           busy,
    output logic                           fault,
    output logic [$clog2(STACK_DEPTH):0]   depth
);

    localparam int WC_W = $clog2(WAIT_MAX + 1);
    localparam logic [WC_W-1:0] c_WAIT_LAST = WC_W'(WAIT_MAX - 1);

    useq_state_e      r_state;
    logic             r_busy;
    logic             r_fault;
    logic [CNT_W-1:0] r_loop_cnt;
    logic [WC_W-1:0]  r_wait_cnt;

    useq_state_e      w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WC_W-1:0]  w_wait_nxt;
    br_type_e         w_op;
    logic [UPC_W-1:0] w_upc_inc;
    logic [UPC_W-1:0] w_stack_top;
    logic             w_flag;
    logic             w_hold;
    logic             w_exec;
    logic             w_err;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;

    useq_stack #(
        .UPC_W       (UPC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .din     (w_upc_inc),
        .dout    (w_stack_top),
        .depth   (depth),
        .full    (w_full),
        .empty   (w_empty)
    );

    // Decode: hold vs. execute, stack error detection, push/pop strobes
    always_comb begin
        w_op      = br_type_e'(br_type);
        w_upc_inc = upc + 1'b1;
        w_flag    = flags[cond_sel];
        w_hold    = ((r_state == ST_RUN)  && uwait && !mem_ready) ||
                    ((r_state == ST_WAIT) && !mem_ready);
        w_exec    = (r_state != ST_FAULT) && !w_hold;
        w_err     = w_exec && (((w_op == BR_CALL) && w_full) ||
                               ((w_op == BR_RET)  && w_empty));
        w_push    = w_exec && (w_op == BR_CALL) && !w_full;
        w_pop     = w_exec && (w_op == BR_RET)  && !w_empty;
    end

    // Zero-latency load/increment selection toward the upc register
    always_comb begin
        load_incr = 1'b0;
        upc_next  = w_upc_inc;
        if (!reset_n) begin
            load_incr = 1'b1;
            upc_next  = '0;
        end else if ((r_state == ST_FAULT) || w_err) begin
            load_incr = 1'b1;
            upc_next  = FAULT_VEC;
        end else if (w_hold) begin
            load_incr = 1'b1;
            upc_next  = upc;
        end else begin
            case (w_op)
                BR_JMP, BR_CALL: begin
                    load_incr = 1'b1;
                    upc_next  = br_addr;
                end
                BR_JC: begin
                    if (w_flag) begin
                        load_incr = 1'b1;
                        upc_next  = br_addr;
                    end
                end
                BR_JNC: begin
                    if (!w_flag) begin
                        load_incr = 1'b1;
                        upc_next  = br_addr;
                    end
                end
                BR_RET: begin
                    load_incr = 1'b1;
                    upc_next  = w_stack_top;
                end
                BR_DJNZ: begin
                    // Counts of 0 and 1 both fall through
                    if (r_loop_cnt > CNT_W'(1)) begin
                        load_incr = 1'b1;
                        upc_next  = br_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state, wait timer and loop counter
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = '0;
        w_cnt_nxt   = r_loop_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_err) begin
                    w_state_nxt = ST_FAULT;
                end else if (uwait && !mem_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!mem_ready) begin
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_wait_nxt = r_wait_cnt + 1'b1;
                    end
                end else if (w_err) begin
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_FAULT;
        endcase
        if (w_exec) begin
            if (w_op == BR_LDCNT) begin
                w_cnt_nxt = br_addr[CNT_W-1:0];
            end else if ((w_op == BR_DJNZ) && (r_loop_cnt != '0)) begin
                w_cnt_nxt = r_loop_cnt - 1'b1;
            end
        end
    end

    // State register with registered busy/fault flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_RUN;
            r_busy     <= 1'b0;
            r_fault    <= 1'b0;
            r_loop_cnt <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt == ST_WAIT);
            r_fault    <= (w_state_nxt == ST_FAULT);
            r_loop_cnt <= w_cnt_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    assign busy  = r_busy;
    assign fault = r_fault;

endmodule : useq_branch_ctrl
`default_nettype wire

// File: tb/tb_useq_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_useq_branch_ctrl
// Description : Self-checking bench for useq_branch_ctrl. Directed scenarios
//               followed by random traffic, compared against a queue-based
//               behavioural model of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_useq_branch_ctrl;

    localparam int OP_NEXT  = 0;
    localparam int OP_JMP   = 1;
    localparam int OP_JC    = 2;
    localparam int OP_JNC   = 3;
    localparam int OP_CALL  = 4;
    localparam int OP_RET   = 5;
    localparam int OP_LDCNT = 6;
    localparam int OP_DJNZ  = 7;
    localparam int WAIT_MAX = 15;
    localparam int DEPTH    = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] upc;
    logic [2:0] br_type;
    logic [4:0] br_addr;
    logic [1:0] cond_sel;
    logic [3:0] flags;
    logic       uwait;
    logic       mem_ready;
    logic       load_incr;
    logic [4:0] upc_next;
    logic       busy;
    logic       fault;
    logic [2:0] depth;

    int n_cmp = 0;
    int n_mis = 0;

    // Behavioural model: 0 = running, 1 = waiting, 2 = faulted
    int         m_state;
    logic [4:0] m_stack[$];
    int         m_cnt;
    int         m_wcnt;

    useq_branch_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .upc       (upc),
        .br_type   (br_type),
        .br_addr   (br_addr),
        .cond_sel  (cond_sel),
        .flags     (flags),
        .uwait     (uwait),
        .mem_ready (mem_ready),
        .load_incr (load_incr),
        .upc_next  (upc_next),
        .busy      (busy),
        .fault     (fault),
        .depth     (depth)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Assert reset at the current time (no edge needed) and check it bites at once
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_load_incr", 32'(load_incr), 32'd1);
        chk("rst_upc_next",  32'(upc_next),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_fault",     32'(fault),     32'd0);
        chk("rst_depth",     32'(depth),     32'd0);
        m_state = 0;
        m_stack.delete();
        m_cnt   = 0;
        m_wcnt  = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One clock cycle: drive, check against the model, advance the model
    task automatic cycle(input logic [4:0] u, input int bt, input logic [4:0] ba,
                         input logic [1:0] cs, input logic [3:0] fl,
                         input logic uw, input logic mr);
        logic       e_load;
        logic [4:0] e_next;
        logic [4:0] u_inc;
        bit         held;
        bit         take;
        int         nst;
        upc       = u;
        br_type   = 3'(bt);
        br_addr   = ba;
        cond_sel  = cs;
        flags     = fl;
        uwait     = uw;
        mem_ready = mr;
        #1;
        chk("busy",  32'(busy),  32'(m_state == 1));
        chk("fault", 32'(fault), 32'(m_state == 2));
        chk("depth", 32'(depth), 32'(m_stack.size()));

        u_inc  = u + 5'd1;
        e_load = 1'b0;
        e_next = u_inc;
        nst    = m_state;
        held   = (m_state == 0 && uw && !mr) || (m_state == 1 && !mr);
        if (m_state == 2) begin
            e_load = 1'b1;
            e_next = 5'h1F;
        end else if (held) begin
            e_load = 1'b1;
            e_next = u;
            if (m_state == 0) nst = 1;
            else if (m_wcnt == WAIT_MAX - 1) nst = 2;
        end else begin
            nst  = 0;
            take = 1'b0;
            case (bt)
                OP_JMP:  take = 1'b1;
                OP_JC:   take = fl[cs];
                OP_JNC:  take = !fl[cs];
                OP_CALL: begin
                    if (m_stack.size() == DEPTH) nst = 2;
                    else begin
                        m_stack.push_back(u_inc);
                        take = 1'b1;
                    end
                end
                OP_RET: begin
                    if (m_stack.size() == 0) nst = 2;
                    else begin
                        e_load = 1'b1;
                        e_next = m_stack.pop_back();
                    end
                end
                OP_LDCNT: m_cnt = int'(ba);
                OP_DJNZ: begin
                    if (m_cnt > 1) take = 1'b1;
                    if (m_cnt > 0) m_cnt = m_cnt - 1;
                end
                default: ;
            endcase
            if (take) begin
                e_load = 1'b1;
                e_next = ba;
            end
            if (nst == 2) begin
                e_load = 1'b1;
                e_next = 5'h1F;
            end
        end
        chk("load_incr", 32'(load_incr), 32'(e_load));
        chk("upc_next",  32'(upc_next),  32'(e_next));

        if (nst == 1 && m_state == 1) m_wcnt = m_wcnt + 1;
        else m_wcnt = 0;
        m_state = nst;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        upc       = '0;
        br_type   = '0;
        br_addr   = '0;
        cond_sel  = '0;
        flags     = '0;
        uwait     = 1'b0;
        mem_ready = 1'b1;
        do_reset();

        // Basic sequencing
        cycle(5'd3,  OP_NEXT, 5'd9,  2'd0, 4'h0, 1'b0, 1'b1);
        cycle(5'd4,  OP_JMP,  5'd12, 2'd0, 4'h0, 1'b0, 1'b1);
        cycle(5'd12, OP_JC,   5'd17, 2'd2, 4'h4, 1'b0, 1'b1);
        cycle(5'd17, OP_JC,   5'd2,  2'd1, 4'h4, 1'b0, 1'b1);
        cycle(5'd18, OP_JNC,  5'd25, 2'd1, 4'h4, 1'b0, 1'b1);
        cycle(5'd25, OP_JNC,  5'd7,  2'd3, 4'h8, 1'b0, 1'b1);

        // Call / return, including the wrap from 31
        cycle(5'd5,  OP_CALL, 5'd20, 2'd0, 4'h0, 1'b0, 1'b1);
        cycle(5'd20, OP_RET,  5'd0,  2'd0, 4'h0, 1'b0, 1'b1);
        cycle(5'd31, OP_CALL, 5'd7,  2'd0, 4'h0, 1'b0, 1'b1);
        cycle(5'd7,  OP_RET,  5'd0,  2'd0, 4'h0, 1'b0, 1'b1);
        cycle(5'd31, OP_NEXT, 5'd0,  2'd0, 4'h0, 1'b0, 1'b1);

        // Counted loop
        cycle(5'd1,  OP_LDCNT, 5'd3, 2'd0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            cycle(5'd9, OP_DJNZ, 5'd8, 2'd0, 4'h0, 1'b0, 1'b1);

        // Wait on memory with a CALL pending: single push on the ready cycle
        for (int i = 0; i < 4; i++)
            cycle(5'd10, OP_CALL, 5'd4, 2'd0, 4'h0, 1'b1, 1'b0);
        cycle(5'd10, OP_CALL, 5'd4, 2'd0, 4'h0, 1'b1, 1'b1);
        cycle(5'd4,  OP_NEXT, 5'd0, 2'd0, 4'h0, 1'b0, 1'b1);

        // Overflow: five calls, then fault is sticky
        do_reset();
        for (int i = 0; i < 5; i++)
            cycle(5'(i), OP_CALL, 5'd16, 2'd0, 4'h0, 1'b0, 1'b1);
        cycle(5'd1, OP_RET, 5'd3, 2'd0, 4'h0, 1'b0, 1'b1);
        cycle(5'd2, OP_JMP, 5'd3, 2'd0, 4'h0, 1'b1, 1'b0);

        // Underflow on an empty stack
        do_reset();
        cycle(5'd6, OP_RET,  5'd0, 2'd0, 4'h0, 1'b0, 1'b1);
        cycle(5'd6, OP_NEXT, 5'd0, 2'd0, 4'h0, 1'b0, 1'b1);

        // Wait timeout: one RUN hold cycle plus fifteen WAIT cycles
        do_reset();
        for (int i = 0; i < 1 + WAIT_MAX; i++)
            cycle(5'd8, OP_NEXT, 5'd0, 2'd0, 4'h0, 1'b1, 1'b0);
        cycle(5'd8, OP_NEXT, 5'd0, 2'd0, 4'h0, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a wait
        do_reset();
        for (int i = 0; i < 5; i++)
            cycle(5'd8, OP_JMP, 5'd2, 2'd0, 4'h0, 1'b1, 1'b0);
        #2;
        do_reset();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            if (m_state == 2 && ($urandom % 3) == 0) begin
                do_reset();
            end else begin
                cycle(5'($urandom), int'($urandom % 8), 5'($urandom),
                      2'($urandom), 4'($urandom),
                      1'(($urandom % 4) == 0), 1'(($urandom % 3) != 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_useq_branch_ctrl
`default_nettype wire
